mc_ctrl: RTL and testbench

Multi-cycle MIPS controller: a Moore/Mealy hybrid state machine that sequences each instruction through fetch, decode, execute, memory and write-back. Replaces the single-cycle combinational decoder in the next-generation datapath, driving the same control signal set with the same encodings, plus per-state write enables. Parametrised by memory wait states so one block serves both zero-latency and slow-memory builds. Sits between the IR/ALU Zero flag and the PC, IR, GRF, ALU, EXT and DM enables.

---
 rtl/mc_ctrl_if.sv | 31 +++
 rtl/mc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// The controller holds the master modport; the datapath (or bench) holds the slave.
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Function;
  logic       Zero;
  logic       PCWrite;
  logic       IRWrite;
  logic [1:0] NPCOp;
  logic [1:0] ALUOp;
  logic       RegWrite;
  logic [1:0] EXTOp;
  logic       MemWrite;
  logic [1:0] RegDst;
  logic       ALUSrc;
  logic [1:0] WDSrc;
  logic [3:0] State;
  logic       Illegal;

  modport master (
    input  Op, Function, Zero,
    output PCWrite, IRWrite, NPCOp, ALUOp, RegWrite, EXTOp, MemWrite,
           RegDst, ALUSrc, WDSrc, State, Illegal
  );

  modport slave (
    output Op, Function, Zero,
    input  PCWrite, IRWrite, NPCOp, ALUOp, RegWrite, EXTOp, MemWrite,
           RegDst, ALUSrc, WDSrc, State, Illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/write-back
// and stretches memory-facing states by MEM_WAIT cycles.
module mc_ctrl #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  mc_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXE    = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWR  = 4'd5,
    MEMWB  = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic       last_cycle;
  logic       in_wait;

  logic is_rtype, op_addu, op_subu, op_jr, op_ori, op_lw, op_sw, op_beq, op_lui, op_jal;

  assign is_rtype = (bus.Op == 6'h00);
  assign op_addu  = is_rtype && (bus.Function == 6'h21);
  assign op_subu  = is_rtype && (bus.Function == 6'h23);
  assign op_jr    = is_rtype && (bus.Function == 6'h08);
  assign op_ori   = (bus.Op == 6'h0D);
  assign op_lw    = (bus.Op == 6'h23);
  assign op_sw    = (bus.Op == 6'h2B);
  assign op_beq   = (bus.Op == 6'h04);
  assign op_lui   = (bus.Op == 6'h0F);
  assign op_jal   = (bus.Op == 6'h03);

  assign last_cycle = (wait_cnt == WAIT_LAST);
  assign in_wait    = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign bus.State  = state;

  // Counter restarts on any state change so each wait state sees 0..MEM_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= 4'd0;
      else if (in_wait)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.NPCOp    = 2'b00;
    bus.ALUOp    = 2'b00;
    bus.RegWrite = 1'b0;
    bus.EXTOp    = 2'b00;
    bus.MemWrite = 1'b0;
    bus.RegDst   = 2'b00;
    bus.ALUSrc   = 1'b0;
    bus.WDSrc    = 2'b00;
    bus.Illegal  = 1'b0;

    case (state)
      FETCH: begin
        if (last_cycle) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          state_nxt   = DECODE;
        end
      end
      DECODE: begin
        if (op_addu || op_subu || op_ori || op_lui)
          state_nxt = EXE;
        else if (op_lw || op_sw)
          state_nxt = MEMADR;
        else if (op_beq)
          state_nxt = BRANCH;
        else if (op_jal || op_jr)
          state_nxt = JUMP;
        else begin
          bus.Illegal = 1'b1;
          state_nxt   = FETCH;
        end
      end
      EXE: begin
        if (op_subu) begin
          bus.ALUOp = 2'b01;
        end else if (op_ori) begin
          bus.ALUOp  = 2'b10;
          bus.ALUSrc = 1'b1;
        end else if (op_lui) begin
          bus.ALUSrc = 1'b1;
          bus.EXTOp  = 2'b10;
        end
        state_nxt = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = is_rtype ? 2'b01 : 2'b00;
        state_nxt    = FETCH;
      end
      MEMADR: begin
        bus.ALUSrc = 1'b1;
        bus.EXTOp  = 2'b01;
        state_nxt  = op_lw ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.ALUSrc = 1'b1;
        bus.EXTOp  = 2'b01;
        if (last_cycle)
          state_nxt = MEMWB;
      end
      MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.WDSrc    = 2'b01;
        state_nxt    = FETCH;
      end
      MEMWR: begin
        if (last_cycle) begin
          bus.MemWrite = 1'b1;
          state_nxt    = FETCH;
        end
      end
      BRANCH: begin
        bus.ALUOp   = 2'b01;
        bus.NPCOp   = 2'b01;
        bus.PCWrite = bus.Zero;
        state_nxt   = FETCH;
      end
      JUMP: begin
        bus.PCWrite = 1'b1;
        if (op_jal) begin
          bus.NPCOp    = 2'b10;
          bus.RegWrite = 1'b1;
          bus.RegDst   = 2'b10;
          bus.WDSrc    = 2'b10;
        end else begin
          bus.NPCOp = 2'b11;
        end
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: one instance with no memory wait states and one with two,
// expected per-cycle control vectors queued by stimulus and checked by a monitor.
module tb_mc_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       irw;
    logic [1:0] npc;
    logic [1:0] alu;
    logic       regw;
    logic [1:0] ext;
    logic       memw;
    logic [1:0] rdst;
    logic       asrc;
    logic [1:0] wds;
    logic       ill;
  } exp_t;

  logic clk;
  logic rst_n;
  bit   sel;
  int   checks;
  int   errors;

  exp_t  exp_q[$];
  string name_q[$];

  mc_ctrl_if if0 ();
  mc_ctrl_if if2 ();

  mc_ctrl #(.MEM_WAIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  mc_ctrl #(.MEM_WAIT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t E(input logic [3:0] st, input logic pcw, input logic irw,
                             input logic [1:0] npc, input logic [1:0] alu, input logic regw,
                             input logic [1:0] ext, input logic memw, input logic [1:0] rdst,
                             input logic asrc, input logic [1:0] wds, input logic ill);
    exp_t e;
    e.st = st; e.pcw = pcw; e.irw = irw; e.npc = npc; e.alu = alu; e.regw = regw;
    e.ext = ext; e.memw = memw; e.rdst = rdst; e.asrc = asrc; e.wds = wds; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t sample(input bit s);
    exp_t a;
    if (!s) begin
      a.st = if0.State; a.pcw = if0.PCWrite; a.irw = if0.IRWrite; a.npc = if0.NPCOp;
      a.alu = if0.ALUOp; a.regw = if0.RegWrite; a.ext = if0.EXTOp; a.memw = if0.MemWrite;
      a.rdst = if0.RegDst; a.asrc = if0.ALUSrc; a.wds = if0.WDSrc; a.ill = if0.Illegal;
    end else begin
      a.st = if2.State; a.pcw = if2.PCWrite; a.irw = if2.IRWrite; a.npc = if2.NPCOp;
      a.alu = if2.ALUOp; a.regw = if2.RegWrite; a.ext = if2.EXTOp; a.memw = if2.MemWrite;
      a.rdst = if2.RegDst; a.asrc = if2.ALUSrc; a.wds = if2.WDSrc; a.ill = if2.Illegal;
    end
    return a;
  endfunction

  // Monitor: one queued expectation per clock, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = sample(sel);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s dut=%0d actual=%h expected=%h (st/pcw/irw/npc/alu/regw/ext/memw/rdst/asrc/wds/ill)",
                 n, sel ? 2 : 0, a, e);
      end
    end
  end

  task automatic cyc(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z);
    if0.Op = op; if0.Function = fn; if0.Zero = z;
    if2.Op = op; if2.Function = fn; if2.Zero = z;
  endtask

  task automatic do_reset(input bit s, input exp_t rexp);
    sel   = s;
    rst_n = 1'b0;
    cyc("reset", rexp);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t f0_last, f2_idle, dec, idle2;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    sel    = 1'b0;
    set_in(6'h00, 6'h21, 1'b0);
    f0_last = E(0,1,1,0,0,0,0,0,0,0,0,0);
    f2_idle = E(0,0,0,0,0,0,0,0,0,0,0,0);
    dec     = E(1,0,0,0,0,0,0,0,0,0,0,0);
    idle2   = f2_idle;
    @(posedge clk);
    #1;

    // MEM_WAIT=0: with no wait, the reset FETCH cycle is already the final one.
    do_reset(1'b0, f0_last);
    set_in(6'h00, 6'h21, 1'b0);
    cyc("addu_fetch",  f0_last);
    cyc("addu_decode", dec);
    cyc("addu_exe",    E(2,0,0,0,0,0,0,0,0,0,0,0));
    cyc("addu_aluwb",  E(7,0,0,0,0,1,0,0,1,0,0,0));
    set_in(6'h00, 6'h23, 1'b0);
    cyc("subu_fetch",  f0_last);
    cyc("subu_decode", dec);
    cyc("subu_exe",    E(2,0,0,0,1,0,0,0,0,0,0,0));
    cyc("subu_aluwb",  E(7,0,0,0,0,1,0,0,1,0,0,0));
    set_in(6'h0D, 6'h21, 1'b0);
    cyc("ori_fetch",   f0_last);
    cyc("ori_decode",  dec);
    cyc("ori_exe",     E(2,0,0,0,2,0,0,0,0,1,0,0));
    cyc("ori_aluwb",   E(7,0,0,0,0,1,0,0,0,0,0,0));
    set_in(6'h0F, 6'h00, 1'b0);
    cyc("lui_fetch",   f0_last);
    cyc("lui_decode",  dec);
    cyc("lui_exe",     E(2,0,0,0,0,0,2,0,0,1,0,0));
    cyc("lui_aluwb",   E(7,0,0,0,0,1,0,0,0,0,0,0));
    set_in(6'h04, 6'h00, 1'b1);
    cyc("beq_t_fetch",  f0_last);
    cyc("beq_t_decode", dec);
    cyc("beq_t_branch", E(8,1,0,1,1,0,0,0,0,0,0,0));
    set_in(6'h04, 6'h00, 1'b0);
    cyc("beq_n_fetch",  f0_last);
    cyc("beq_n_decode", dec);
    cyc("beq_n_branch", E(8,0,0,1,1,0,0,0,0,0,0,0));
    set_in(6'h03, 6'h00, 1'b0);
    cyc("jal_fetch",   f0_last);
    cyc("jal_decode",  dec);
    cyc("jal_jump",    E(9,1,0,2,0,1,0,0,2,0,2,0));
    set_in(6'h00, 6'h08, 1'b0);
    cyc("jr_fetch",    f0_last);
    cyc("jr_decode",   dec);
    cyc("jr_jump",     E(9,1,0,3,0,0,0,0,0,0,0,0));
    set_in(6'h3F, 6'h00, 1'b0);
    cyc("ill_op_fetch",  f0_last);
    cyc("ill_op_decode", E(1,0,0,0,0,0,0,0,0,0,0,1));
    set_in(6'h00, 6'h20, 1'b0);
    cyc("ill_fn_fetch",  f0_last);
    cyc("ill_fn_decode", E(1,0,0,0,0,0,0,0,0,0,0,1));
    set_in(6'h00, 6'h21, 1'b0);
    cyc("after_ill_fetch", f0_last);

    // MEM_WAIT=2: lw then sw, then an async reset inside a MEMWR wait.
    set_in(6'h23, 6'h00, 1'b0);
    do_reset(1'b1, idle2);
    cyc("lw_fetch0",  f2_idle);
    cyc("lw_fetch1",  f2_idle);
    cyc("lw_fetch2",  f0_last);
    cyc("lw_decode",  dec);
    cyc("lw_memadr",  E(3,0,0,0,0,0,1,0,0,1,0,0));
    cyc("lw_memrd0",  E(4,0,0,0,0,0,1,0,0,1,0,0));
    cyc("lw_memrd1",  E(4,0,0,0,0,0,1,0,0,1,0,0));
    cyc("lw_memrd2",  E(4,0,0,0,0,0,1,0,0,1,0,0));
    cyc("lw_memwb",   E(6,0,0,0,0,1,0,0,0,0,1,0));
    set_in(6'h2B, 6'h00, 1'b0);
    cyc("sw_fetch0",  f2_idle);
    cyc("sw_fetch1",  f2_idle);
    cyc("sw_fetch2",  f0_last);
    cyc("sw_decode",  dec);
    cyc("sw_memadr",  E(3,0,0,0,0,0,1,0,0,1,0,0));
    cyc("sw_memwr0",  E(5,0,0,0,0,0,0,0,0,0,0,0));
    cyc("sw_memwr1",  E(5,0,0,0,0,0,0,0,0,0,0,0));
    cyc("sw_memwr2",  E(5,0,0,0,0,0,0,1,0,0,0,0));
    cyc("sw2_fetch0", f2_idle);
    cyc("sw2_fetch1", f2_idle);
    cyc("sw2_fetch2", f0_last);
    cyc("sw2_decode", dec);
    cyc("sw2_memadr", E(3,0,0,0,0,0,1,0,0,1,0,0));
    cyc("sw2_memwr0", E(5,0,0,0,0,0,0,0,0,0,0,0));
    rst_n = 1'b0;
    cyc("rst_in_memwr", idle2);
    rst_n = 1'b1;
    set_in(6'h04, 6'h00, 1'b1);
    cyc("beq2_fetch0", f2_idle);
    cyc("beq2_fetch1", f2_idle);
    cyc("beq2_fetch2", f0_last);
    cyc("beq2_decode", dec);
    cyc("beq2_branch", E(8,1,0,1,1,0,0,0,0,0,0,0));
    cyc("beq2_refetch", f2_idle);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
